nandn_pipe: RTL and testbench

- Parametrised, pipelined N-input reduction gate; successor to the fixed 8-input delay-modelled NAND used in the CLA datapath.
- Reduces an N_IN-bit vector through a tree of FANIN-input levels, with a register after every level.
- Selectable op per transaction: AND, NAND, OR or NOR.
- Valid/ready handshake with full backpressure, so it drops into streaming CLA generate/propagate paths.

---
 rtl/nandn_pkg.sv | 52 +++++
 rtl/nandn_tree_stage.sv | 55 +++++
 rtl/nandn_pipe.sv | 77 +++++++
 tb/tb_nandn_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nandn_pkg.sv
// Shared types and elaboration helpers for the pipelined N-input reduction gate.
package nandn_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_NAND = 2'b01,
        OP_OR   = 2'b10,
        OP_NOR  = 2'b11
    } op_e;

    // Number of FANIN-wide tree levels needed to reduce n bits down to one.
    function automatic int clog_fanin(input int n, input int f);
        int lv;
        int cap;
        lv  = 0;
        cap = 1;
        while (cap < n) begin
            cap = cap * f;
            lv  = lv + 1;
        end
        return lv;
    endfunction

    function automatic int level_width(input int w0, input int f, input int k);
        int w;
        w = w0;
        for (int i = 0; i < k; i++) w = w / f;
        return w;
    endfunction

    // Bit offset of level k inside the flattened tree vector (levels 0..k-1 precede it).
    function automatic int level_offset(input int w0, input int f, input int k);
        int off;
        int w;
        off = 0;
        w   = w0;
        for (int i = 0; i < k; i++) begin
            off = off + w;
            w   = w / f;
        end
        return off;
    endfunction

    function automatic logic op_inv_in(input op_e op);
        return (op == OP_OR) || (op == OP_NOR);
    endfunction

    function automatic logic op_inv_out(input op_e op);
        return (op == OP_NAND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/nandn_tree_stage.sv
// One registered level of the AND tree: groups of FANIN bits are ANDed and
// captured together with the stage valid bit and the op that travels alongside.
module nandn_tree_stage
    import nandn_pkg::*;
#(
    parameter int W_IN  = 4,
    parameter int FANIN = 4,
    localparam int W_OUT = W_IN / FANIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  op_e              in_op,
    input  logic [W_IN-1:0]  in_data,
    output logic             out_valid,
    output op_e              out_op,
    output logic [W_OUT-1:0] out_data
);

    logic             valid_q, valid_d;
    op_e              op_q, op_d;
    logic [W_OUT-1:0] data_q, data_d;

    // en is low only when this stage holds a result that cannot move on.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        if (en) begin
            valid_d = in_valid;
            op_d    = in_op;
            for (int g = 0; g < W_OUT; g++) begin
                data_d[g] = &in_data[g*FANIN +: FANIN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= OP_AND;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_data  = data_q;

endmodule

// File: rtl/nandn_pipe.sv
// Pipelined N-input AND/NAND/OR/NOR reduction with valid/ready backpressure.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends on ready, and in_ready depends combinationally on out_ready.
module nandn_pipe
    import nandn_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int FANIN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_data,
    input  logic [1:0]      in_op,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int LEVELS = clog_fanin(N_IN, FANIN);
    localparam int W0     = FANIN ** LEVELS;
    localparam int TOTAL  = level_offset(W0, FANIN, LEVELS + 1);

    // All tree levels packed back to back; level 0 is the padded entry vector.
    logic [TOTAL-1:0]  tree;
    logic [LEVELS:0]   vld;
    op_e               op_lvl [LEVELS+1];
    logic [LEVELS:1]   stage_en;
    logic [W0-1:0]     entry;

    always_comb begin
        entry             = '1;
        entry[N_IN-1:0]   = in_data ^ {N_IN{op_inv_in(op_e'(in_op))}};
    end

    assign tree[W0-1:0] = entry;
    assign vld[0]       = in_valid;
    assign op_lvl[0]    = op_e'(in_op);

    // Stage k may load when out_ready is high or some stage from k onward is empty.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        stage_en = '0;
        for (int k = LEVELS; k >= 1; k--) begin
            all_full    = all_full & vld[k];
            stage_en[k] = out_ready | ~all_full;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int WI = level_width(W0, FANIN, k - 1);
        localparam int OI = level_offset(W0, FANIN, k - 1);
        localparam int OO = level_offset(W0, FANIN, k);

        nandn_tree_stage #(
            .W_IN  (WI),
            .FANIN (FANIN)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (stage_en[k]),
            .in_valid  (vld[k-1]),
            .in_op     (op_lvl[k-1]),
            .in_data   (tree[OI +: WI]),
            .out_valid (vld[k]),
            .out_op    (op_lvl[k]),
            .out_data  (tree[OO +: WI/FANIN])
        );
    end

    assign in_ready  = stage_en[1];
    assign out_valid = vld[LEVELS];
    assign out_data  = tree[TOTAL-1] ^ op_inv_out(op_lvl[LEVELS]);

endmodule

// File: tb/tb_nandn_pipe.sv
// Self-checking bench for nandn_pipe: default 8/4 instance plus a 5/2 instance.
module tb_nandn_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       in_valid;
  logic       in_ready;
  logic       out_data;
  logic       out_valid;
  logic       out_ready;

  logic [4:0] in5_data;
  logic [1:0] in5_op;
  logic       in5_valid;
  logic       in5_ready;
  logic       out5_data;
  logic       out5_valid;
  logic       out5_ready;

  typedef struct {
    logic d;
    int   cyc;
    bit   lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp5_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit lat_chk = 1'b1;
  bit rnd_bp  = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nandn_pipe #(.N_IN(8), .FANIN(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  nandn_pipe #(.N_IN(5), .FANIN(2)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in5_data),
    .in_op     (in5_op),
    .in_valid  (in5_valid),
    .in_ready  (in5_ready),
    .out_data  (out5_data),
    .out_valid (out5_valid),
    .out_ready (out5_ready)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic model(input logic [7:0] d, input logic [1:0] op, input int n);
    logic all_one;
    logic any_one;
    all_one = 1'b1;
    any_one = 1'b0;
    for (int i = 0; i < n; i++) begin
      all_one = all_one & d[i];
      any_one = any_one | d[i];
    end
    case (op)
      2'b00:   return all_one;
      2'b01:   return ~all_one;
      2'b10:   return any_one;
      default: return ~any_one;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      exp5_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else if (out_ready) begin
          e = exp_q.pop_front();
          check("data", out_data, e.d);
          if (e.lat) check("latency", cyc - e.cyc, 2);
        end else check("stall_hold", out_data, exp_q[0].d);
      end
      if (in_valid && in_ready)
        exp_q.push_back('{model(in_data, in_op, 8), cyc, lat_chk});

      if (out5_valid) begin
        if (exp5_q.size() == 0) check("unexpected_out5", out5_valid, 0);
        else if (out5_ready) begin
          e = exp5_q.pop_front();
          check("data5", out5_data, e.d);
          check("latency5", cyc - e.cyc, 3);
        end
      end
      if (in5_valid && in5_ready)
        exp5_q.push_back('{model({3'b000, in5_data}, in5_op, 5), cyc, 1'b1});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] d, input logic [1:0] op);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_op    = op;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send5(input logic [4:0] d, input logic [1:0] op);
    bit ok;
    ok        = 1'b0;
    in5_data  = d;
    in5_op    = op;
    in5_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in5_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send5_timeout", in5_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    in_data    = 8'hFF;
    in_op      = 2'b00;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    in5_data   = '0;
    in5_op     = 2'b00;
    in5_valid  = 1'b0;
    out5_ready = 1'b1;

    // reset held two cycles with a valid input present
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out5_valid", out5_valid, 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 0);
    @(posedge clk);
    #1;

    // NAND basics, spaced out and then back to back
    send(8'hFF, 2'b01);
    idle(3);
    send(8'hFE, 2'b01);
    send(8'h00, 2'b01);
    idle(4);

    // op changes on consecutive cycles
    send(8'hFF, 2'b00);
    send(8'h00, 2'b10);
    send(8'h10, 2'b11);
    send(8'hFF, 2'b01);
    idle(4);

    // backpressure: two accepted, third held off
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(8'hFF, 2'b00);
    send(8'h7F, 2'b10);
    in_data  = 8'h00;
    in_op    = 2'b11;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h00, 2'b11);
    send(8'h01, 2'b00);
    idle(5);

    // random stimulus with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = (i % 3 == 0) ? 8'hFF : ((i % 3 == 1) ? 8'h00 : 8'($urandom_range(0, 255)));
      send(d, 2'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    rnd_bp   = 1'b0;
    #0 out_ready = 1'b1;
    idle(6);

    // mid-stream reset discards two in-flight results
    out_ready = 1'b0;
    send(8'hFF, 2'b00);
    send(8'h00, 2'b00);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(8'hFE, 2'b01);
    idle(5);

    // five-input instance, three levels with padding
    send5(5'h1F, 2'b00);
    send5(5'h00, 2'b10);
    send5(5'h1E, 2'b00);
    send5(5'h10, 2'b11);
    send5(5'h00, 2'b01);
    for (int i = 0; i < 10; i++) send5(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    in5_valid = 1'b0;

    // drain
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp5_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
    check("drain5", exp5_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
